// File: rtl/alu_pkg.sv
// Shared definitions for the ALU, the alu_issue stage in front of it, and
// their benches: operation encoding, ALU pipeline latency and default width.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } operation_t;

    localparam int ALU_LATENCY = 2;
    localparam int ALU_WIDTH   = 6;

endpackage

// File: rtl/alu_issue_if.sv
// Bus bundles used by alu_issue.
//   alu_issue_cmd_if : command handshake (cmd_valid/cmd_ready + op/a/b).
//                      master = command producer, slave = alu_issue.
//   alu_issue_alu_if : unhandshaked ALU input port plus its completion return.
//                      master = alu_issue, slave = ALU.
interface alu_issue_cmd_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    import alu_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    operation_t       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_a, cmd_b, output cmd_ready);
endinterface

interface alu_issue_alu_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    import alu_pkg::*;

    logic             alu_valid;
    operation_t       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_done;

    modport master (output alu_valid, alu_op, alu_a, alu_b, input alu_done);
    modport slave  (input alu_valid, alu_op, alu_a, alu_b, output alu_done);
endinterface

// File: rtl/alu_issue_fifo.sv
// Synchronous DEPTH x DW command FIFO for alu_issue.
// Ports:
//   clk, rst_n          clock / async active-low reset (pointers and count)
//   push_i, wdata_i     write request and data (ignored when full)
//   pop_i               read request (ignored when empty)
//   clear_i             synchronous discard of all entries; wins over push/pop
//   rdata_o             head entry (valid when !empty_o)
//   count_o             occupancy; full_o / empty_o derived from it
module alu_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 14,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (do_push && !do_pop) count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/alu_issue.sv
// Command-issue stage in front of the ALU. Buffers commands from a
// valid/ready channel in a FIFO and issues at most one per cycle onto the
// ALU input port, limited to MAX_INFLIGHT operations awaiting alu_done.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   cmd_if       command channel (slave): cmd_valid/cmd_ready, cmd_op/a/b
//   flush        synchronous discard of queued commands (in-flight kept)
//   alu_if       ALU port (master): alu_valid/op/a/b out, alu_done in
//   count        FIFO occupancy
//   idle         FIFO empty and nothing in flight
//   issued_cnt, done_cnt  saturating issue/completion counters, present
//                only when ALU_ISSUE_STATS_EN is defined
module alu_issue import alu_pkg::*; #(
    parameter int WIDTH        = ALU_WIDTH,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    alu_issue_cmd_if.slave               cmd_if,
    input  logic                         flush,
    alu_issue_alu_if.master              alu_if,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         idle
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]                  issued_cnt,
    output logic [15:0]                  done_cnt
`endif
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int DW  = 2 + 2 * WIDTH;
    localparam int IFW = $clog2(MAX_INFLIGHT + 1);

    logic [DW-1:0]    head;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic             push, issue, done_eff;
    logic [IFW-1:0]   inflight_q, inflight_d;
    logic             alu_valid_q;
    operation_t       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;

    assign cmd_if.cmd_ready = !fifo_full && !flush;
    assign push = cmd_if.cmd_valid && cmd_if.cmd_ready;

    // A completion arriving this cycle frees its slot in time for an issue
    // on the same edge.
    assign issue = !fifo_empty && !flush &&
                   ((inflight_q < IFW'(MAX_INFLIGHT)) || alu_if.alu_done);

    // A completion with nothing outstanding is spurious and dropped.
    assign done_eff = alu_if.alu_done && (inflight_q != '0);

    alu_issue_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (issue),
        .clear_i (flush),
        .wdata_i ({cmd_if.cmd_op, cmd_if.cmd_a, cmd_if.cmd_b}),
        .rdata_o (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !done_eff)      inflight_d = inflight_q + IFW'(1);
        else if (!issue && done_eff) inflight_d = inflight_q - IFW'(1);
    end

    // Payload holds its last value when nothing issues.
    always_comb begin
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        if (issue) begin
            alu_op_d = operation_t'(head[DW-1 -: 2]);
            alu_a_d  = head[2*WIDTH-1 -: WIDTH];
            alu_b_d  = head[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q  <= '0;
            alu_valid_q <= 1'b0;
            alu_op_q    <= OP_NOP;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
        end else begin
            inflight_q  <= inflight_d;
            alu_valid_q <= issue;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
        end
    end

    assign alu_if.alu_valid = alu_valid_q;
    assign alu_if.alu_op    = alu_op_q;
    assign alu_if.alu_a     = alu_a_q;
    assign alu_if.alu_b     = alu_b_q;
    assign count            = fifo_count;
    assign idle             = (fifo_count == '0) && (inflight_q == '0);

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] issued_cnt_q, done_cnt_q;

    // Saturating counters; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt_q <= '0;
            done_cnt_q   <= '0;
        end else begin
            if (issue && issued_cnt_q != 16'hFFFF)          issued_cnt_q <= issued_cnt_q + 16'd1;
            if (alu_if.alu_done && done_cnt_q != 16'hFFFF)  done_cnt_q   <= done_cnt_q + 16'd1;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign done_cnt   = done_cnt_q;
`endif

    // A completion with no operation outstanding points at a broken ALU link.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(alu_if.alu_done && inflight_q == '0));
        end
    end
endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
    import alu_pkg::*;

    localparam int W  = 6;
    localparam int D  = 4;
    localparam int MI = 2;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_issue_cmd_if #(.WIDTH(W)) cif ();
    alu_issue_alu_if #(.WIDTH(W)) aif ();
    alu_issue_cmd_if #(.WIDTH(W)) cif1 ();
    alu_issue_alu_if #(.WIDTH(W)) aif1 ();
    logic          flush = 1'b0;
    logic          flush1 = 1'b0;
    logic [CW-1:0] count, count1;
    logic          idle, idle1;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] iss_cnt, dn_cnt, iss_cnt1, dn_cnt1;
`endif

    alu_issue #(.WIDTH(W), .DEPTH(D), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_if(cif), .flush(flush), .alu_if(aif),
        .count(count), .idle(idle)
`ifdef ALU_ISSUE_STATS_EN
        , .issued_cnt(iss_cnt), .done_cnt(dn_cnt)
`endif
    );

    alu_issue #(.WIDTH(W), .DEPTH(D), .MAX_INFLIGHT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_if(cif1), .flush(flush1), .alu_if(aif1),
        .count(count1), .idle(idle1)
`ifdef ALU_ISSUE_STATS_EN
        , .issued_cnt(iss_cnt1), .done_cnt(dn_cnt1)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] alu_fn(operation_t op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            default: return '0;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- Behavioural ALU for the MAX_INFLIGHT=2 instance ----
    typedef struct { int due; logic [W-1:0] res; } pend_t;
    pend_t        pq[$];
    bit           hold_done = 1'b0;
    logic [W-1:0] alu_res;
    int           n_iss = 0, n_done = 0;
    int           t0[$];
    logic [W-1:0] ia[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pq.delete();
            aif.alu_done <= 1'b0;
            alu_res      <= '0;
        end else begin
            aif.alu_done <= 1'b0;
            if (aif.alu_valid) begin
                pq.push_back('{cyc + ALU_LATENCY - 1, alu_fn(aif.alu_op, aif.alu_a, aif.alu_b)});
                n_iss++;
                t0.push_back(cyc);
                ia.push_back(aif.alu_a);
            end
            if (pq.size() != 0 && pq[0].due <= cyc && !hold_done) begin
                aif.alu_done <= 1'b1;
                alu_res      <= pq[0].res;
                void'(pq.pop_front());
                n_done++;
            end
        end
    end

    // ---------------- Fixed-latency ALU for the MAX_INFLIGHT=1 instance ---
    logic         v1a;
    logic [W-1:0] r1a, res1;
    int           t1[$];
    logic [W-1:0] r1[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1a <= 1'b0; aif1.alu_done <= 1'b0; r1a <= '0; res1 <= '0;
        end else begin
            v1a           <= aif1.alu_valid;
            aif1.alu_done <= v1a;
            r1a           <= alu_fn(aif1.alu_op, aif1.alu_a, aif1.alu_b);
            res1          <= r1a;
            if (aif1.alu_valid) t1.push_back(cyc);
            if (aif1.alu_done)  r1.push_back(res1);
        end
    end

    // ---------------- Reference model: queue + in-flight count -----------
    typedef struct { operation_t op; logic [W-1:0] a; logic [W-1:0] b; } cmd_t;
    cmd_t mq[$];
    cmd_t m_exp;
    int   minfl = 0;
    bit   mon_en = 1'b0;
    bit   m_rdy, m_iss, m_done;

    always begin
        @(posedge clk);
        if (mon_en && rst_n) begin
            m_rdy  = (mq.size() < D) && !flush;
            chk("cmd_ready", 32'(cif.cmd_ready), 32'(m_rdy));
            m_iss  = (mq.size() != 0) && !flush && (minfl < MI || aif.alu_done);
            m_done = aif.alu_done && (minfl > 0);
            if (m_iss) m_exp = mq.pop_front();
            if (flush) mq.delete();
            else if (cif.cmd_valid && m_rdy) mq.push_back('{cif.cmd_op, cif.cmd_a, cif.cmd_b});
            minfl = minfl + (m_iss ? 1 : 0) - (m_done ? 1 : 0);
            #1;
            chk("alu_valid", 32'(aif.alu_valid), 32'(m_iss));
            if (m_iss) begin
                chk("alu_op", 32'(aif.alu_op), 32'(m_exp.op));
                chk("alu_a", 32'(aif.alu_a), 32'(m_exp.a));
                chk("alu_b", 32'(aif.alu_b), 32'(m_exp.b));
            end
            chk("count", 32'(count), 32'(mq.size()));
            chk("idle", 32'(idle), 32'(mq.size() == 0 && minfl == 0));
        end
    end

    task automatic push(operation_t op, logic [W-1:0] a, logic [W-1:0] b);
        bit got = 1'b0;
        cif.cmd_valid = 1'b1; cif.cmd_op = op; cif.cmd_a = a; cif.cmd_b = b;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            got = cif.cmd_ready;
        end
        chk("push_accepted", 32'(got), 32'd1);
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(string name, int lim);
        bit ok = 1'b0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(posedge clk); #1;
            ok = idle;
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    typedef struct { operation_t op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; } vec_t;
    vec_t vec[7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc, t_iss, t_done, base, iss_before, done_before;
        bit found;

        vec[0] = '{OP_ADD, 6'd5,    6'd3,    6'd8};
        vec[1] = '{OP_SUB, 6'd1,    6'd2,    6'h3F};
        vec[2] = '{OP_ADD, 6'h3F,   6'd1,    6'd0};
        vec[3] = '{OP_SUB, 6'd0,    6'd1,    6'h3F};
        vec[4] = '{OP_NOP, 6'd7,    6'd9,    6'd0};
        vec[5] = '{OP_ADD, 6'h20,   6'h21,   6'h01};
        vec[6] = '{OP_SUB, 6'h2A,   6'h0A,   6'h20};

        cif.cmd_valid = 1'b0; cif.cmd_op = OP_NOP; cif.cmd_a = '0; cif.cmd_b = '0;
        cif1.cmd_valid = 1'b0; cif1.cmd_op = OP_NOP; cif1.cmd_a = '0; cif1.cmd_b = '0;

        // Reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_cmd_ready", 32'(cif.cmd_ready), 32'd1);
        chk("rst_alu_valid", 32'(aif.alu_valid), 32'd0);
        chk("rst_alu_op", 32'(aif.alu_op), 32'(OP_NOP));
        chk("rst_alu_a", 32'(aif.alu_a), 32'd0);
        chk("rst_alu_b", 32'(aif.alu_b), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Table: one command at a time, latency and ALU result
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cif.cmd_valid = 1'b1; cif.cmd_op = vec[i].op; cif.cmd_a = vec[i].a; cif.cmd_b = vec[i].b;
            @(posedge clk); #1; t_acc = cyc;
            @(negedge clk); cif.cmd_valid = 1'b0;
            found = 1'b0; t_iss = -1;
            for (int k = 0; k < 8 && !found; k++) begin
                @(posedge clk); #1;
                if (aif.alu_valid) begin
                    found = 1'b1; t_iss = cyc;
                    chk("tv_op", 32'(aif.alu_op), 32'(vec[i].op));
                    chk("tv_a", 32'(aif.alu_a), 32'(vec[i].a));
                    chk("tv_b", 32'(aif.alu_b), 32'(vec[i].b));
                end
            end
            chk("tv_issue_latency", 32'(t_iss - t_acc), 32'd1);
            found = 1'b0; t_done = -1;
            for (int k = 0; k < 8 && !found; k++) begin
                @(posedge clk); #1;
                if (aif.alu_done) begin
                    found = 1'b1; t_done = cyc;
                    chk("tv_result", 32'(alu_res), 32'(vec[i].res));
                end
            end
            chk("tv_done_latency", 32'(t_done - t_acc), 32'd3);
            @(posedge clk); #1;
            chk("tv_idle_after", 32'(idle), 32'd1);
        end

        // MAX_INFLIGHT=2: first two issues back to back
        @(negedge clk);
        base = t0.size();
        push(OP_ADD, 6'd1, 6'd1);
        push(OP_ADD, 6'd2, 6'd2);
        push(OP_ADD, 6'd3, 6'd3);
        wait_idle("b2b_drain", 30);
        chk("b2b_n_issues", 32'(t0.size() - base), 32'd3);
        if (t0.size() - base >= 2) chk("b2b_spacing", 32'(t0[base+1] - t0[base]), 32'd1);

        // MAX_INFLIGHT=1: issues spaced three cycles apart
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            cif1.cmd_valid = 1'b1; cif1.cmd_op = OP_SUB; cif1.cmd_a = 6'd1; cif1.cmd_b = 6'd2;
            @(negedge clk);
        end
        cif1.cmd_valid = 1'b0;
        chk("thr_count_after_push", 32'(count1), 32'd3);
        for (int k = 0; k < 40 && r1.size() < 4; k++) @(posedge clk);
        repeat (2) @(posedge clk); #1;
        chk("thr_n_issues", 32'(t1.size()), 32'd4);
        chk("thr_n_results", 32'(r1.size()), 32'd4);
        for (int j = 0; j + 1 < t1.size(); j++) chk("thr_spacing", 32'(t1[j+1] - t1[j]), 32'd3);
        for (int j = 0; j < r1.size(); j++) chk("thr_result", 32'(r1[j]), 32'h3F);
        chk("thr_count_end", 32'(count1), 32'd0);
        chk("thr_idle_end", 32'(idle1), 32'd1);

        // Full / wrap with completions held back
        @(negedge clk);
        base = ia.size();
        hold_done = 1'b1;
        push(OP_ADD, 6'd10, 6'd1);
        push(OP_ADD, 6'd11, 6'd1);
        repeat (4) @(negedge clk);
        fork
            begin
                for (int j = 0; j < 5; j++) push(OP_ADD, 6'(12 + j), 6'd1);
            end
            begin
                found = 1'b0;
                for (int k = 0; k < 30 && !found; k++) begin
                    @(posedge clk); #1;
                    found = (count == CW'(D));
                end
                chk("full_reached", 32'(found), 32'd1);
                chk("full_cmd_ready", 32'(cif.cmd_ready), 32'd0);
                repeat (3) @(posedge clk); #1;
                chk("full_count_hold", 32'(count), 32'(D));
                @(negedge clk);
                hold_done = 1'b0;
            end
        join
        wait_idle("full_drain", 60);
        chk("full_n_issues", 32'(ia.size() - base), 32'd7);
        for (int k = 0; k < 7 && base + k < ia.size(); k++)
            chk("full_order", 32'(ia[base+k]), 32'(10 + k));

        // Flush with 3 queued and 2 in flight
        @(negedge clk);
        hold_done = 1'b1;
        for (int j = 0; j < 5; j++) push(OP_SUB, 6'(20 + j), 6'd1);
        repeat (4) @(posedge clk); #1;
        chk("fl_count_before", 32'(count), 32'd3);
        chk("fl_idle_before", 32'(idle), 32'd0);
        iss_before = n_iss; done_before = n_done;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("fl_count_after", 32'(count), 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("fl_idle_while_outstanding", 32'(idle), 32'd0);
        @(negedge clk); hold_done = 1'b0;
        wait_idle("fl_drain", 20);
        repeat (5) @(posedge clk); #1;
        chk("fl_no_more_issues", 32'(n_iss), 32'(iss_before));
        chk("fl_dones", 32'(n_done - done_before), 32'd2);

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cif.cmd_valid = 1'($urandom_range(0, 1));
            cif.cmd_op    = operation_t'($urandom_range(0, 2));
            cif.cmd_a     = W'($urandom);
            cif.cmd_b     = W'($urandom);
            flush         = ($urandom_range(0, 39) == 0);
            hold_done     = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        cif.cmd_valid = 1'b0; flush = 1'b0; hold_done = 1'b0;
        wait_idle("rand_drain", 100);

`ifdef ALU_ISSUE_STATS_EN
        repeat (2) @(posedge clk); #1;
        chk("stats_issued", 32'(iss_cnt), 32'(n_iss));
        chk("stats_done", 32'(dn_cnt), 32'(n_done));
        chk("stats1_issued", 32'(iss_cnt1), 32'd4);
        chk("stats1_done", 32'(dn_cnt1), 32'd4);
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
